axi_lite_regfile_slave: RTL

//  AXI4-Lite slave register file that terminates the BFM master's S00_AXI port in the harness block design.

---
 rtl/axi_lite_regfile_slave.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_regfile_slave.sv
// AXI4-Lite slave register file: NUM_REGS 32-bit registers on a 4-byte stride, byte strobes,
// SLVERR on out-of-range indices, register contents and per-register write pulses exported.
module axi_lite_regfile_slave #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
  parameter int unsigned NUM_REGS           = 4
) (
  input  logic                                   ACLK,
  input  logic                                   ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                             S_AXI_AWPROT,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                             S_AXI_ARPROT,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]                    reg_wr_pulse
);

  localparam int unsigned DATA_W = C_S_AXI_DATA_WIDTH;
  localparam int unsigned ADDR_W = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned IDX_W  = ADDR_W - 2;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic { W_IDLE, W_RESP } w_state_t;
  typedef enum logic { R_IDLE, R_DATA } r_state_t;

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;

  w_state_t w_state, w_state_n;
  r_state_t r_state, r_state_n;

  logic              aw_have, aw_have_n, w_have, w_have_n;
  logic [IDX_W-1:0]  aw_idx;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              awready_n, wready_n, bvalid_n, arready_n, rvalid_n;
  logic [1:0]        bresp_n, rresp_n;
  logic [DATA_W-1:0] rdata_n, r_word;
  logic              aw_hs, w_hs, ar_hs, commit, c_ok, r_ok;
  logic [IDX_W-1:0]  c_idx, r_idx;
  logic [DATA_W-1:0] c_data;
  logic [STRB_W-1:0] c_strb;

  logic unused;
  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign reg_out = regs;

  // Write channel next state: commit as soon as both AW and W are held (latched or arriving now)
  always_comb begin
    w_state_n = w_state;
    aw_have_n = aw_have;
    w_have_n  = w_have;
    awready_n = S_AXI_AWREADY;
    wready_n  = S_AXI_WREADY;
    bvalid_n  = S_AXI_BVALID;
    bresp_n   = S_AXI_BRESP;
    commit    = 1'b0;
    aw_hs     = S_AXI_AWVALID & S_AXI_AWREADY;
    w_hs      = S_AXI_WVALID & S_AXI_WREADY;
    c_idx     = aw_hs ? S_AXI_AWADDR[ADDR_W-1:2] : aw_idx;
    c_data    = w_hs ? S_AXI_WDATA : wdata_q;
    c_strb    = w_hs ? S_AXI_WSTRB : wstrb_q;
    c_ok      = 32'(c_idx) < NUM_REGS;
    case (w_state)
      W_IDLE: begin
        aw_have_n = aw_have | aw_hs;
        w_have_n  = w_have | w_hs;
        if (aw_have_n && w_have_n) begin
          commit    = 1'b1;
          w_state_n = W_RESP;
          aw_have_n = 1'b0;
          w_have_n  = 1'b0;
          awready_n = 1'b0;
          wready_n  = 1'b0;
          bvalid_n  = 1'b1;
          bresp_n   = c_ok ? RESP_OKAY : RESP_SLVERR;
        end else begin
          awready_n = ~aw_have_n;
          wready_n  = ~w_have_n;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          w_state_n = W_IDLE;
          bvalid_n  = 1'b0;
          awready_n = 1'b1;
          wready_n  = 1'b1;
        end
      end
      default: w_state_n = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state       <= W_IDLE;
      aw_have       <= 1'b0;
      w_have        <= 1'b0;
      aw_idx        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
    end else begin
      w_state       <= w_state_n;
      aw_have       <= aw_have_n;
      w_have        <= w_have_n;
      S_AXI_AWREADY <= awready_n;
      S_AXI_WREADY  <= wready_n;
      S_AXI_BVALID  <= bvalid_n;
      S_AXI_BRESP   <= bresp_n;
      if (aw_hs) aw_idx <= S_AXI_AWADDR[ADDR_W-1:2];
      if (w_hs) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
    end
  end

  // Register storage and one-cycle write pulses; a zero strobe still pulses a valid index
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      regs         <= '0;
      reg_wr_pulse <= '0;
    end else begin
      reg_wr_pulse <= '0;
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
        if (commit && c_ok && (IDX_W'(k) == c_idx)) begin
          reg_wr_pulse[k] <= 1'b1;
          for (int unsigned b = 0; b < STRB_W; b++) begin
            if (c_strb[b]) regs[k][8*b +: 8] <= c_data[8*b +: 8];
          end
        end
      end
    end
  end

  // Read channel next state: data sampled from pre-write contents on the AR edge
  always_comb begin
    r_state_n = r_state;
    arready_n = S_AXI_ARREADY;
    rvalid_n  = S_AXI_RVALID;
    rdata_n   = S_AXI_RDATA;
    rresp_n   = S_AXI_RRESP;
    ar_hs     = S_AXI_ARVALID & S_AXI_ARREADY;
    r_idx     = S_AXI_ARADDR[ADDR_W-1:2];
    r_ok      = 32'(r_idx) < NUM_REGS;
    r_word    = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      if (IDX_W'(k) == r_idx) r_word = regs[k];
    end
    case (r_state)
      R_IDLE: begin
        arready_n = 1'b1;
        if (ar_hs) begin
          r_state_n = R_DATA;
          arready_n = 1'b0;
          rvalid_n  = 1'b1;
          rdata_n   = r_ok ? r_word : '0;
          rresp_n   = r_ok ? RESP_OKAY : RESP_SLVERR;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          r_state_n = R_IDLE;
          rvalid_n  = 1'b0;
          arready_n = 1'b1;
        end
      end
      default: r_state_n = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state       <= R_IDLE;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= RESP_OKAY;
    end else begin
      r_state       <= r_state_n;
      S_AXI_ARREADY <= arready_n;
      S_AXI_RVALID  <= rvalid_n;
      S_AXI_RDATA   <= rdata_n;
      S_AXI_RRESP   <= rresp_n;
    end
  end

endmodule
